seven_seg_scan: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display on the io shield. It consumes a 16-bit hex value with per-digit decimal-point and blank masks and scans the digits one at a time. It drives the active-low io_sel and io_seg pins directly and inserts a blanking gap between digits to suppress ghosting. New values are committed only at frame boundaries, so the display never tears.

---
 rtl/seven_seg_scan.sv | 130 +++++++++++++
 tb/tb_seven_seg_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg_scan: 4-digit multiplexed seven-segment driver with blanking gap |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module seven_seg_scan #(
  parameter int ON_CYCLES    = 1500,
  parameter int BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  io_sel,
  output logic [7:0]  io_seg,
  output logic        digit_tick,
  output logic        frame_tick
);

  localparam int C_MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int C_CW   = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

  typedef enum logic [0:0] {S_BLANK = 1'b0, S_ON = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [C_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]        r_idx;
  logic [15:0]       r_sh_value, r_act_value;
  logic [3:0]        r_sh_dp, r_sh_blank, r_act_dp, r_act_blank;
  logic              r_pending;

  logic              w_on_done, w_blank_done, w_commit;
  logic [3:0]        w_nibble;
  logic [6:0]        w_glyph;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    w_on_done    = (r_state == S_ON)    && (r_cnt == C_CW'(ON_CYCLES - 1));
    w_blank_done = (r_state == S_BLANK) && (r_cnt == C_CW'(BLANK_CYCLES - 1));
    w_commit     = w_on_done && (r_idx == 2'd3);
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    if (w_on_done) begin
      w_state_nxt = S_BLANK;
      w_cnt_nxt   = '0;
    end else if (w_blank_done) begin
      w_state_nxt = S_ON;
      w_cnt_nxt   = '0;
    end
    w_nibble = r_act_value[{r_idx, 2'b00} +: 4];
    w_glyph  = hex7(w_nibble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_on_done) r_idx <= r_idx + 2'd1;
    end
  end

  // A load coinciding with the commit edge skips the shadow and lands in active directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '0;
      r_pending   <= 1'b0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
      if (load) begin
        r_act_value <= value;
        r_act_dp    <= dp;
        r_act_blank <= blank;
      end else if (r_pending) begin
        r_act_value <= r_sh_value;
        r_act_dp    <= r_sh_dp;
        r_act_blank <= r_sh_blank;
      end
    end else if (load) begin
      r_sh_value <= value;
      r_sh_dp    <= dp;
      r_sh_blank <= blank;
      r_pending  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_sel     <= 4'hF;
      io_seg     <= 8'hFF;
      digit_tick <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      digit_tick <= w_on_done;
      frame_tick <= w_commit;
      if (w_blank_done) begin
        if (r_act_blank[r_idx]) begin
          io_sel <= 4'hF;
          io_seg <= 8'hFF;
        end else begin
          io_sel <= ~(4'b0001 << r_idx);
          io_seg <= ~{r_act_dp[r_idx], w_glyph};
        end
      end else if (w_on_done) begin
        io_sel <= 4'hF;
        io_seg <= 8'hFF;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seven_seg_scan: randomized bench against a schedule-based display model |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_seven_seg_scan;

  localparam int ON_CYCLES    = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int C_P          = ON_CYCLES + BLANK_CYCLES;
  localparam int C_FR         = 4 * C_P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        digit_tick, frame_tick;

  seven_seg_scan #(.ON_CYCLES(ON_CYCLES), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .io_sel(io_sel), .io_seg(io_seg), .digit_tick(digit_tick), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] c_hex [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edges since reset release plus shadow/active display contents.
  int          m_n;
  logic [15:0] m_sh_v, m_ac_v;
  logic [3:0]  m_sh_d, m_sh_b, m_ac_d, m_ac_b;
  bit          m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, m_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_pend = 0;
    m_sh_v = '0; m_sh_d = '0; m_sh_b = '0;
    m_ac_v = '0; m_ac_d = '0; m_ac_b = '0;
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_sel"}, {28'd0, io_sel}, 32'hF);
    check({tag, "_seg"}, {24'd0, io_seg}, 32'hFF);
    check({tag, "_dtick"}, {31'd0, digit_tick}, 32'd0);
    check({tag, "_ftick"}, {31'd0, frame_tick}, 32'd0);
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    logic [3:0] exp_sel, onehot, nib;
    logic [7:0] exp_seg;
    int dg;
    bit lit, commit;
    load = ld; value = v; dp = d; blank = b;
    @(posedge clk);
    #1;
    m_n++;
    commit = (m_n % C_FR) == 0;
    if (commit) begin
      if (ld) begin
        m_ac_v = v; m_ac_d = d; m_ac_b = b;
      end else if (m_pend) begin
        m_ac_v = m_sh_v; m_ac_d = m_sh_d; m_ac_b = m_sh_b;
      end
      m_pend = 0;
    end else if (ld) begin
      m_sh_v = v; m_sh_d = d; m_sh_b = b; m_pend = 1;
    end
    lit = (m_n % C_P) >= BLANK_CYCLES;
    dg  = (m_n / C_P) % 4;
    exp_sel = 4'hF;
    exp_seg = 8'hFF;
    if (lit && !m_ac_b[dg]) begin
      onehot  = 4'b0001 << dg;
      nib     = 4'(m_ac_v >> (4 * dg));
      exp_sel = ~onehot;
      exp_seg = ~{m_ac_d[dg], c_hex[nib]};
    end
    check("io_sel", {28'd0, io_sel}, {28'd0, exp_sel});
    check("io_seg", {24'd0, io_seg}, {24'd0, exp_seg});
    check("digit_tick", {31'd0, digit_tick}, {31'd0, ((m_n % C_P) == 0)});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, commit});
  endtask

  // Idle cycles with random data on the inputs but no load strobe.
  task automatic run_idle(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic run_until_before_commit();
    while (((m_n + 1) % C_FR) != 0) run_idle(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    check_dark("reset");

    // Power-on scan with value 0 on every digit.
    run_idle(3 * C_FR);

    // Load mid-frame; must not show until commit.
    run_idle(7);
    step(1'b1, 16'h1A3F, 4'b0100, 4'b0000);
    run_idle(2 * C_FR);

    // Blanked digits 1 and 3.
    run_idle(5);
    step(1'b1, 16'h1A3F, 4'b0000, 4'b1010);
    run_idle(2 * C_FR);

    // Load exactly on the commit edge.
    run_until_before_commit();
    step(1'b1, 16'h0008, 4'b0000, 4'b0000);
    run_idle(2 * C_FR);

    // Two loads in one frame; second must win.
    run_idle(3);
    step(1'b1, 16'h1111, 4'b0000, 4'b0000);
    run_idle(6);
    step(1'b1, 16'h2222, 4'b0000, 4'b0000);
    run_idle(2 * C_FR);

    // Randomized loads, occasionally landing on the commit edge.
    for (int i = 0; i < 20 * C_FR; i++) begin
      if ($urandom_range(0, 11) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom & 32'h5));
      else
        run_idle(1);
    end

    // Asynchronous reset while digit 2 is lit (blank cleared first so it really is lit).
    step(1'b1, 16'hBEEF, 4'b1111, 4'b0000);
    run_idle(2 * C_FR);
    while (!(((m_n % C_P) >= BLANK_CYCLES) && (((m_n / C_P) % 4) == 2))) run_idle(1);
    check("pre_rst_sel", {28'd0, io_sel}, 32'hB);
    #2;
    rst = 1'b1;
    #1;
    check_dark("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_idle(2 * C_FR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
